// File: rtl/ahb_slave_response_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ahb_slave_response_ctrl_pkg                             |
// | Brief    : Shared AHB encodings and controller state type          |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package ahb_slave_response_ctrl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } ctrl_state_e;

  // Number of address bits selecting a byte lane; kept at least 1 so
  // slices stay legal on an 8-bit bus.
  function automatic int lane_bits(input int dw);
    return (dw > 8) ? $clog2(dw / 8) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_response_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ahb_slave_response_ctrl_if                              |
// | Brief    : AHB address/data-phase signals between master and slave |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface ahb_slave_response_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  hselx;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hreadyout;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hselx, haddr, htrans, hwrite, hsize, hready, hwdata,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hselx, haddr, htrans, hwrite, hsize, hready, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_response_ctrl_strobe_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ahb_strobe_gen                                          |
// | Brief    : Byte-enable generation and size/alignment checking      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module ahb_strobe_gen
  import ahb_slave_response_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]                         i_hsize,
  input  logic [lane_bits(DATA_WIDTH)-1:0]   i_addr_lo,
  output logic [DATA_WIDTH/8-1:0]            o_be,
  output logic                               o_misaligned,
  output logic                               o_oversize
);
  localparam int          NB      = DATA_WIDTH / 8;
  localparam int unsigned LOG2_NB = $clog2(NB);

  logic [31:0] w_lane;
  logic [31:0] w_nbytes;

  // 2^hsize ones starting at the addressed lane; flags for illegal size or alignment
  always_comb begin
    o_be     = '0;
    w_nbytes = 32'd1 << i_hsize;
    w_lane   = (NB > 1) ? 32'(i_addr_lo) : 32'd0;
    o_oversize   = (32'(i_hsize) > LOG2_NB);
    o_misaligned = ((w_lane & (w_nbytes - 32'd1)) != 32'd0);
    for (int unsigned b = 0; b < NB; b++) begin
      o_be[b] = (b >= w_lane) && (b < (w_lane + w_nbytes));
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_slave_response_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ahb_slave_response_ctrl                                 |
// | Brief    : AHB slave data-phase sequencer in front of a memory port|
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module ahb_slave_response_ctrl
  import ahb_slave_response_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_WIDTH = 4
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  ahb_slave_response_ctrl_if.slave ahb,
  input  logic [WAIT_WIDTH-1:0]   cfg_wait_states,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic                    mem_err,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LW = lane_bits(DATA_WIDTH);

  ctrl_state_e           r_state;
  ctrl_state_e           w_state_nxt;
  logic [WAIT_WIDTH-1:0] r_wait_cnt;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [NB-1:0]         r_mem_be;
  logic [DATA_WIDTH-1:0] r_hrdata;

  logic                  w_capture;
  logic                  w_check_fail;
  logic                  w_misaligned;
  logic                  w_oversize;
  logic                  w_done;
  logic [NB-1:0]         w_be;

  ahb_strobe_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_strobe_gen (
    .i_hsize      (ahb.hsize),
    .i_addr_lo    (ahb.haddr[LW-1:0]),
    .o_be         (w_be),
    .o_misaligned (w_misaligned),
    .o_oversize   (w_oversize)
  );

  // A new address phase is only accepted while this slave shows ready
  // (IDLE or the second ERROR cycle); ERR1 ignores the address bus.
  assign w_capture    = ((r_state == ST_IDLE) || (r_state == ST_ERR2)) &&
                        ahb.hselx && ahb.hready && ahb.htrans[1];
  assign w_check_fail = w_misaligned || w_oversize;
  assign w_done       = (r_state == ST_ACCESS) && mem_ack;

  // Next-state selection for the data-phase sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        if (w_capture) begin
          if (w_check_fail)                      w_state_nxt = ST_ERR1;
          else if (cfg_wait_states != '0)        w_state_nxt = ST_WAIT;
          else                                   w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == WAIT_WIDTH'(1)) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (mem_ack) w_state_nxt = mem_err ? ST_ERR1 : ST_IDLE;
      end
      ST_ERR1:  w_state_nxt = ST_ERR2;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Address-phase capture and wait-state countdown
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_wait_cnt <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_be   <= '0;
    end else if (w_capture) begin
      r_wait_cnt <= cfg_wait_states;
      r_mem_we   <= ahb.hwrite;
      r_mem_addr <= ahb.haddr;
      r_mem_be   <= w_be;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt - WAIT_WIDTH'(1);
    end
  end

  // Read data is refreshed only by a successful read and held otherwise
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)                            r_hrdata <= '0;
    else if (w_done && !mem_err && !r_mem_we) r_hrdata <= mem_rdata;
  end

  assign ahb.hreadyout = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign ahb.hresp     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR
                                                                        : HRESP_OKAY;
  assign ahb.hrdata    = r_hrdata;
  assign mem_req       = (r_state == ST_ACCESS);
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_be        = r_mem_be;
  assign mem_wdata     = ahb.hwdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_response_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_ahb_slave_response_ctrl                              |
// | Brief    : Directed and randomized bench with transfer-level model |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_ahb_slave_response_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WW = 4;

  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic [WW-1:0] cfg_wait_states;
  logic          mem_req, mem_we, mem_ack, mem_err;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;

  ahb_slave_response_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ahb_slave_response_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_WIDTH(WW)) dut (
    .hclk            (hclk),
    .hresetn         (hresetn),
    .ahb             (bus),
    .cfg_wait_states (cfg_wait_states),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_err         (mem_err),
    .mem_rdata       (mem_rdata)
  );

  always #5 hclk = ~hclk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_resets = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One expected bus cycle, plus what the memory model drives during it
  typedef struct {
    bit          rdy;
    bit          resp;
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          ack;
    bit          err;
    logic [31:0] mrd;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        cur;
  logic [31:0] m_hrdata;

  function automatic rec_t mk(input bit rdy, input bit resp, input bit req);
    rec_t r;
    r.rdy  = rdy;  r.resp = resp; r.req = req;
    r.we   = 1'b0; r.addr = '0;   r.be  = '0;
    r.wd   = $urandom;
    r.rd   = m_hrdata;
    r.ack  = ($urandom_range(0, 3) == 0);
    r.err  = 1'($urandom_range(0, 1));
    r.mrd  = $urandom;
    return r;
  endfunction

  function automatic logic [3:0] model_be(input int size, input logic [31:0] addr);
    int nb   = 1 << size;
    int lane = int'(addr % 4);
    return 4'(((1 << nb) - 1) << lane);
  endfunction

  // Expand one captured transfer into its expected data-phase cycles
  task automatic plan(input int size, input logic [31:0] addr, input bit we,
                      input int w, input int k, input bit e,
                      input logic [31:0] wdata, input logic [31:0] rdata);
    rec_t r;
    if (size > 2 || (addr % (32'd1 << size)) != 0) begin
      exp_q.push_back(mk(0, 1, 0));
      exp_q.push_back(mk(1, 1, 0));
      return;
    end
    for (int i = 0; i < w; i++) begin
      r = mk(0, 0, 0); r.wd = wdata; exp_q.push_back(r);
    end
    for (int j = 0; j <= k; j++) begin
      r = mk(0, 0, 1);
      r.we = we; r.addr = addr; r.be = model_be(size, addr); r.wd = wdata;
      r.ack = (j == k); r.err = (j == k) ? e : r.err; r.mrd = rdata;
      exp_q.push_back(r);
    end
    if (e) begin
      exp_q.push_back(mk(0, 1, 0));
      exp_q.push_back(mk(1, 1, 0));
    end else begin
      if (!we) m_hrdata = rdata;
      exp_q.push_back(mk(1, 0, 0));
    end
  endtask

  task automatic addr_phase(input bit sel, input logic [1:0] tr, input bit we,
                            input logic [2:0] size, input logic [31:0] addr, input bit rdy);
    bus.hselx = sel; bus.htrans = tr; bus.hwrite = we;
    bus.hsize = size; bus.haddr = addr; bus.hready = rdy;
  endtask

  initial begin
    int          c, size, w, k;
    bit          we, e, rdy;
    logic [31:0] addr, wdata, rdata;

    addr_phase(0, 2'd0, 0, 3'd0, 32'd0, 1);
    bus.hwdata = '0; cfg_wait_states = '0;
    mem_ack = 0; mem_err = 0; mem_rdata = '0;

    // Reset values
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_hreadyout", bus.hreadyout, 1);
    chk("rst_hresp",     bus.hresp, 0);
    chk("rst_hrdata",    bus.hrdata, 0);
    chk("rst_mem_req",   mem_req, 0);
    chk("rst_mem_we",    mem_we, 0);
    chk("rst_mem_addr",  mem_addr, 0);
    chk("rst_mem_be",    mem_be, 0);
    hresetn = 1'b1;

    // Zero-wait read of 0x10, ack in D0
    @(posedge hclk); #1;
    addr_phase(1, 2'd2, 0, 3'd2, 32'h10, 1);
    @(posedge hclk); #1;
    addr_phase(0, 2'd0, 0, 3'd0, 32'd0, 1);
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    chk("zw_d0_mem_req",   mem_req, 1);
    chk("zw_d0_hreadyout", bus.hreadyout, 0);
    chk("zw_d0_mem_addr",  mem_addr, 32'h10);
    chk("zw_d0_mem_be",    mem_be, 4'hF);
    @(posedge hclk); #1;
    mem_ack = 0;
    @(negedge hclk);
    chk("zw_d1_hreadyout", bus.hreadyout, 1);
    chk("zw_d1_hresp",     bus.hresp, 0);
    chk("zw_d1_hrdata",    bus.hrdata, 32'hDEAD_BEEF);
    chk("zw_d1_mem_req",   mem_req, 0);

    // Three-wait write of 0x12345678 to 0x4; config changed mid-transfer
    @(posedge hclk); #1;
    addr_phase(1, 2'd2, 1, 3'd2, 32'h4, 1);
    cfg_wait_states = 4'd3; bus.hwdata = 32'h1234_5678;
    for (int i = 0; i <= 4; i++) begin
      @(posedge hclk); #1;
      if (i == 0) begin
        addr_phase(0, 2'd0, 0, 3'd0, 32'd0, 1);
        cfg_wait_states = 4'd0;
      end
      mem_ack = (i == 3);
      @(negedge hclk);
      if (i < 3) begin
        chk("ws_wait_mem_req",   mem_req, 0);
        chk("ws_wait_hreadyout", bus.hreadyout, 0);
      end else if (i == 3) begin
        chk("ws_d3_mem_req",   mem_req, 1);
        chk("ws_d3_mem_we",    mem_we, 1);
        chk("ws_d3_mem_be",    mem_be, 4'hF);
        chk("ws_d3_mem_wdata", mem_wdata, 32'h1234_5678);
      end else begin
        chk("ws_d4_hreadyout", bus.hreadyout, 1);
        chk("ws_d4_hrdata",    bus.hrdata, 32'hDEAD_BEEF);
      end
    end
    mem_ack = 0;

    // Misaligned halfword at 0x3
    @(posedge hclk); #1;
    addr_phase(1, 2'd2, 0, 3'd1, 32'h3, 1);
    @(posedge hclk); #1;
    addr_phase(0, 2'd0, 0, 3'd0, 32'd0, 1);
    @(negedge hclk);
    chk("mis_d0_rdy_resp", {bus.hreadyout, bus.hresp, mem_req}, 3'b010);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("mis_d1_rdy_resp", {bus.hreadyout, bus.hresp, mem_req}, 3'b110);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("mis_d2_rdy_resp", {bus.hreadyout, bus.hresp, mem_req}, 3'b100);

    // Randomized traffic against the transfer-level model
    m_hrdata = 32'hDEAD_BEEF;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge hclk); #1;
      cur = (exp_q.size() > 0) ? exp_q.pop_front() : mk(1, 0, 0);
      mem_ack = cur.ack; mem_err = cur.err; mem_rdata = cur.mrd;
      bus.hwdata = cur.wd;
      cfg_wait_states = WW'($urandom_range(0, 15));
      if (cur.rdy) begin
        c = $urandom_range(0, 9);
        if (c == 0) begin
          addr_phase(1, 2'($urandom_range(0, 1)), 1'($urandom), 3'd2, $urandom, 1);
        end else if (c == 1) begin
          addr_phase(0, 2'($urandom_range(2, 3)), 1'($urandom), 3'd2, $urandom, 1);
        end else begin
          size = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
          addr = $urandom;
          if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
          we    = 1'($urandom);
          rdy   = ($urandom_range(0, 9) != 0);
          w     = $urandom_range(0, 3);
          k     = $urandom_range(0, 2);
          e     = ($urandom_range(0, 5) == 0);
          wdata = $urandom;
          rdata = $urandom;
          cfg_wait_states = WW'(w);
          addr_phase(1, 2'($urandom_range(2, 3)), we, 3'(size), addr, rdy);
          if (rdy) plan(size, addr, we, w, k, e, wdata, rdata);
        end
      end else begin
        addr_phase(1'($urandom), 2'($urandom), 1'($urandom), 3'($urandom), $urandom, 0);
      end
      @(negedge hclk);
      chk("hreadyout", bus.hreadyout, cur.rdy);
      chk("hresp",     bus.hresp, cur.resp);
      chk("mem_req",   mem_req, cur.req);
      chk("hrdata",    bus.hrdata, cur.rd);
      if (cur.req) begin
        chk("mem_we",   mem_we, cur.we);
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_be",   mem_be, cur.be);
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wd);
      end
      // Occasionally pull reset while a request is outstanding
      if (cur.req && !cur.ack && n_resets < 3 && $urandom_range(0, 3) == 0) begin
        #2 hresetn = 1'b0;
        #1;
        chk("arst_mem_req",   mem_req, 0);
        chk("arst_hreadyout", bus.hreadyout, 1);
        chk("arst_hresp",     bus.hresp, 0);
        chk("arst_hrdata",    bus.hrdata, 0);
        chk("arst_mem_be",    mem_be, 0);
        exp_q.delete();
        m_hrdata = '0;
        mem_ack  = 0;
        bus.hready = 0;
        @(negedge hclk);
        hresetn = 1'b1;
        n_resets++;
      end
    end
    chk("reset_injected", (n_resets > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_slave_response_ctrl.md
# ahb_slave_response_ctrl

Slave-side transfer controller for the AHB slave agent's RTL model. Captures AHB address phases, checks them, and issues requests to a simple backing-memory port. It sequences the data phase by driving `hreadyout`, `hresp` and `hrdata`: programmable wait states, OKAY completion, and the two-cycle ERROR response. It is the block whose bus behaviour the slave-side protocol assertions check.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width (matches global package)
- `DATA_WIDTH`, 32, data width, power of two, 8..64
- `WAIT_WIDTH`, 4, width of wait-state count

Ports:
- `hclk`  in  1  clock, all logic on rising edge
- `hresetn`  in  1  asynchronous, active-low reset
- `hselx`  in  1  slave select
- `haddr`  in  ADDR_WIDTH  address
- `htrans`  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- `hwrite`  in  1  1 = write
- `hsize`  in  3  transfer size, log2 bytes
- `hready`  in  1  bus-level ready (mux output)
- `hwdata`  in  DATA_WIDTH  write data, held by master through the data phase
- `hreadyout`  out  1  slave ready
- `hresp`  out  1  0 = OKAY, 1 = ERROR
- `hrdata`  out  DATA_WIDTH  read data
- `cfg_wait_states`  in  WAIT_WIDTH  extra wait cycles inserted before each memory request
- `mem_req`  out  1  memory request, held until ack
- `mem_we`  out  1  write enable
- `mem_addr`  out  ADDR_WIDTH  captured address
- `mem_be`  out  DATA_WIDTH/8  byte enables
- `mem_wdata`  out  DATA_WIDTH  equals `hwdata` (wired through)
- `mem_ack`  in  1  request done, single-cycle pulse
- `mem_err`  in  1  valid with `mem_ack`, memory error
- `mem_rdata`  in  DATA_WIDTH  valid with `mem_ack`

## Operation
- **Reset values:** `hreadyout`=1, `hresp`=0, `hrdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0. State is IDLE.
- **Capture:** at an edge with `hselx && hready && htrans[1]`, latch `haddr`, `hwrite`, `hsize` and `cfg_wait_states`. A later change to `cfg_wait_states` does not affect the transfer in flight.
- **IDLE/BUSY handling:** selected IDLE or BUSY, or not selected, gives a zero-wait OKAY. `hreadyout` stays 1 and nothing is captured.
- **Checks at capture:** ERROR is signalled, and no memory access is made, if either:
  - `hsize` > log2(DATA_WIDTH/8), or
  - `haddr` is not aligned to `hsize`.
- **States:** IDLE, WAIT, ACCESS, ERR1, ERR2.
  - IDLE → ERR1 on a check failure.
  - IDLE → WAIT if the wait count > 0.
  - IDLE → ACCESS otherwise.
  - WAIT decrements its counter and goes to ACCESS after the last wait cycle.
  - ACCESS holds `mem_req`=1 until `mem_ack`. It then goes to ERR1 if `mem_err`=1, else to IDLE with `hreadyout`=1, `hresp`=0, `hrdata`=`mem_rdata` (reads only; unchanged on writes).
  - ERR1 drives `hreadyout`=0, `hresp`=1, then goes to ERR2.
  - ERR2 drives `hreadyout`=1, `hresp`=1, then goes to IDLE.
- **Output outside ERR:** `hresp`=0 in every state except ERR1 and ERR2.
- **Byte enables:** `mem_be` is 2^hsize contiguous ones, starting at byte lane `haddr[log2(DATA_WIDTH/8)-1:0]`.
- **Read data hold:** `hrdata` holds its value until the next read completes.

## Timing
- **Capture edge:** the capture edge is T; D0 is the cycle after T.
- **Memory request:** `mem_req` rises in cycle D0+W, where W is the wait count. `hreadyout`=0 from D0 until completion.
- **Completion:** `mem_ack` sampled in cycle D0+W+k puts `hreadyout`=1 in cycle D0+W+k+1. Minimum data-phase length is 2 cycles.
- **Pipelining:** in the completion cycle (`hreadyout`=1), a new address phase can be captured at the closing edge. Back-to-back transfers have no idle cycle.
- **ERROR response:**
  - Check failure: ERR1 = D0, ERR2 = D0+1.
  - Memory error: ERR1 follows the ack cycle.
  - A transfer presented at the end of ERR2 is captured normally.
  - Address-phase changes during ERR1 are ignored.
- **`mem_ack` handling:** `mem_ack` outside ACCESS is ignored.
- **Async reset mid-transfer:** all outputs return to reset values immediately, `mem_req` drops, and the transfer is abandoned.

## Structure
- **Shared additions to the global package:**
  - `htrans` enum
  - `hresp` constants (OKAY/ERROR)
  - controller state enum
  - `hsize` encodings
- **Sub-module `ahb_strobe_gen`:** combinational. Maps `hsize` and low address bits to `mem_be` and a `misaligned`/`oversize` flag.
- **This module:** capture registers, wait counter, FSM and output registers.

## Test plan
- **Zero-wait read:** `cfg_wait_states`=0, NONSEQ read of 0x0000_0010, size 2, memory acks in D0 with 0xDEAD_BEEF → `mem_req` high in D0 only; `hreadyout` low D0, high D1 with `hrdata`=0xDEAD_BEEF, `hresp`=0.
- **Wait-stated write:** `cfg_wait_states`=3, write of 0x1234_5678 to 0x0000_0004, size 2 → `mem_req` rises in D3 with `mem_we`=1, `mem_be`=4'b1111, `mem_wdata`=0x1234_5678; `hreadyout` low D0–D3, high D4.
- **Misaligned access:** size-1 access to 0x0000_0003 → no `mem_req`; D0 `hreadyout`/`hresp`=0/1, D1 =1/1, D2 ready for the next transfer.
- **Memory error:** `mem_ack` with `mem_err`=1 → two-cycle ERROR follows the ack; `hrdata` unchanged.
- **Back-to-back transfers:** 4 SEQ byte writes to 0x100..0x103 with zero wait and immediate ack → `mem_be` = 0001, 0010, 0100, 1000, each accepted on its completion edge with no idle cycle.
- **Reset mid-transfer:** `hresetn` asserted while in ACCESS with `mem_req`=1 → `mem_req`=0 and `hreadyout`=1 immediately; after release, an IDLE transfer gives a zero-wait OKAY.
